// File: rtl/mem_arbiter.sv
// Round-robin arbiter/sequencer that lets two requesters share one 16x32
// single-port memory: one command cycle on the memory pins, then a read response.
module mem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  a_gnt,
    output logic                  b_gnt,
    output logic [DATA_WIDTH-1:0] a_rdata,
    output logic [DATA_WIDTH-1:0] b_rdata,
    output logic                  a_rvalid,
    output logic                  b_rvalid,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_en,
    input  logic [DATA_WIDTH-1:0] mem_data_out,
    input  logic                  mem_valid_out,
    output logic                  busy,
    output logic                  err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic                    prio;       // 0: A wins a tie, 1: B wins a tie
    logic                    cmd_we;
    logic                    cmd_owner;  // 0: A, 1: B
    logic [ADDR_WIDTH-1:0]   cmd_addr;
    logic [DATA_WIDTH-1:0]   cmd_wdata;

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        a_gnt     = 1'b0;
        b_gnt     = 1'b0;
        mem_en    = 1'b0;
        busy      = (state != IDLE);
        unique case (state)
            IDLE: begin
                // Gated by RST_N so no grant escapes while reset is held.
                if (RST_N) begin
                    a_gnt = a_req && (!b_req || !prio);
                    b_gnt = b_req && (!a_req ||  prio);
                    if (a_req || b_req) state_nxt = EXEC;
                end
            end
            EXEC: begin
                mem_en    = cmd_we;
                state_nxt = cmd_we ? IDLE : RESP;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            prio      <= 1'b0;
            cmd_we    <= 1'b0;
            cmd_owner <= 1'b0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
            a_rdata   <= '0;
            b_rdata   <= '0;
            a_rvalid  <= 1'b0;
            b_rvalid  <= 1'b0;
            err       <= 1'b0;
        end else begin
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
            if (a_gnt || b_gnt) begin
                cmd_we    <= b_gnt ? b_we    : a_we;
                cmd_addr  <= b_gnt ? b_addr  : a_addr;
                cmd_wdata <= b_gnt ? b_wdata : a_wdata;
                cmd_owner <= b_gnt;
                prio      <= ~b_gnt;
            end
            if (state == RESP) begin
                if (cmd_owner) begin
                    b_rdata  <= mem_data_out;
                    b_rvalid <= 1'b1;
                end else begin
                    a_rdata  <= mem_data_out;
                    a_rvalid <= 1'b1;
                end
                if (!mem_valid_out) err <= 1'b1;
            end
        end
    end

    assign mem_address = cmd_addr;
    assign mem_data_in = cmd_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 16x32 memory attached
// to its memory pins; all expected values are hand-derived.
module tb_mem_arbiter;

    localparam int DW = 32;
    localparam int AW = 4;

    logic          CLK = 1'b0;
    logic          RST_N;
    logic          a_req, a_we, b_req, b_we;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_wdata, b_wdata;
    logic          a_gnt, b_gnt, a_rvalid, b_rvalid;
    logic [DW-1:0] a_rdata, b_rdata;
    logic [DW-1:0] mem_data_in, mem_data_out;
    logic [AW-1:0] mem_address;
    logic          mem_en, mem_valid_out, busy, err;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 CLK = ~CLK;

    mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .a_gnt(a_gnt), .b_gnt(b_gnt),
        .a_rdata(a_rdata), .b_rdata(b_rdata),
        .a_rvalid(a_rvalid), .b_rvalid(b_rvalid),
        .mem_data_in(mem_data_in), .mem_address(mem_address), .mem_en(mem_en),
        .mem_data_out(mem_data_out), .mem_valid_out(mem_valid_out),
        .busy(busy), .err(err)
    );

    // Memory model: active-high reset tied to ~RST_N, EN=1 writes, EN=0 registers a read.
    logic [DW-1:0] mem [16];
    logic          mem_valid_r;
    logic          force_invalid = 1'b0;
    assign mem_valid_out = mem_valid_r & ~force_invalid;

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < 16; i++) mem[i] <= '0;
            mem_data_out <= '0;
            mem_valid_r  <= 1'b0;
        end else if (mem_en) begin
            mem[mem_address] <= mem_data_in;
            mem_valid_r      <= 1'b0;
        end else begin
            mem_data_out <= mem[mem_address];
            mem_valid_r  <= 1'b1;
        end
    end

    logic b_rv_seen = 1'b0;
    always @(posedge CLK) if (b_rvalid) b_rv_seen <= 1'b1;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Advance one full cycle; returns at the falling edge so inputs change mid-cycle.
    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
        #1;
    endtask

    task automatic drive_a(input logic req, input logic we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wd);
        a_req = req; a_we = we; a_addr = addr; a_wdata = wd;
    endtask

    task automatic drive_b(input logic req, input logic we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wd);
        b_req = req; b_we = we; b_addr = addr; b_wdata = wd;
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        step();
        RST_N = 1'b1;
        step();
    endtask

    logic exp_a [8];
    logic exp_b [8];

    initial begin
        RST_N = 1'b0;
        drive_a(1'b0, 1'b0, '0, '0);
        drive_b(1'b0, 1'b0, '0, '0);
        step();
        step();

        // Reset state, with a request held to show gnt stays low in reset.
        a_req = 1'b1;
        #1;
        check("rst_a_gnt", a_gnt, 0);
        check("rst_busy", busy, 0);
        check("rst_mem_en", mem_en, 0);
        check("rst_mem_addr", mem_address, 0);
        check("rst_mem_din", mem_data_in, 0);
        check("rst_rvalid", {a_rvalid, b_rvalid}, 0);
        check("rst_a_rdata", a_rdata, 0);
        check("rst_err", err, 0);
        a_req = 1'b0;
        RST_N = 1'b1;
        step();

        // A writes DEADBEEF to 3, then reads it back.
        b_rv_seen = 1'b0;
        drive_a(1'b1, 1'b1, 4'd3, 32'hDEADBEEF);
        #1;
        check("wr_a_gnt_T", a_gnt, 1);
        check("wr_b_gnt_T", b_gnt, 0);
        check("wr_mem_en_T", mem_en, 0);
        step();
        drive_a(1'b1, 1'b0, 4'd3, '0);
        #1;
        check("wr_mem_en_T1", mem_en, 1);
        check("wr_busy_T1", busy, 1);
        check("wr_gnt_T1", a_gnt, 0);
        check("wr_mem_addr_T1", mem_address, 3);
        check("wr_mem_din_T1", mem_data_in, 32'hDEADBEEF);
        step();
        check("rd_a_gnt_T2", a_gnt, 1);
        check("rd_mem_en_T2", mem_en, 0);
        step();
        a_req = 1'b0;
        #1;
        check("rd_mem_en_T3", mem_en, 0);
        step();
        check("rd_busy_T4", busy, 1);
        check("rd_rvalid_T4", a_rvalid, 0);
        step();
        check("rd_rvalid_T5", a_rvalid, 1);
        check("rd_rdata_T5", a_rdata, 32'hDEADBEEF);
        step();
        check("rd_rvalid_T6", a_rvalid, 0);
        check("rd_b_rvalid_quiet", b_rv_seen, 0);

        // Both requesting writes continuously from reset: A, B, A, B every 2 cycles.
        do_reset();
        exp_a = '{1, 0, 0, 0, 1, 0, 0, 0};
        exp_b = '{0, 0, 1, 0, 0, 0, 1, 0};
        drive_a(1'b1, 1'b1, 4'd1, 32'h1);
        drive_b(1'b1, 1'b1, 4'd2, 32'h2);
        for (int i = 0; i < 8; i++) begin
            #1;
            check($sformatf("rr_a_gnt_%0d", i), a_gnt, exp_a[i]);
            check($sformatf("rr_b_gnt_%0d", i), b_gnt, exp_b[i]);
            if (i == 7) begin
                a_req = 1'b0;
                b_req = 1'b0;
            end
            step();
        end
        check("rr_mem1", mem[1], 32'h1);
        check("rr_mem2", mem[2], 32'h2);

        // Write/read collision on address 7 with prio back at A.
        drive_a(1'b1, 1'b1, 4'd7, 32'hA5A5A5A5);
        drive_b(1'b1, 1'b0, 4'd7, '0);
        #1;
        check("col_a_gnt", a_gnt, 1);
        check("col_b_gnt_T", b_gnt, 0);
        step();
        a_req = 1'b0;
        #1;
        check("col_b_gnt_T1", b_gnt, 0);
        step();
        check("col_b_gnt_T2", b_gnt, 1);
        step();
        b_req = 1'b0;
        step();
        check("col_b_rvalid_T4", b_rvalid, 0);
        step();
        check("col_b_rvalid_T5", b_rvalid, 1);
        check("col_b_rdata", b_rdata, 32'hA5A5A5A5);
        check("col_a_rvalid", a_rvalid, 0);
        step();

        // A writes address 0, then a B read is cut by reset in RESP.
        drive_a(1'b1, 1'b1, 4'd0, 32'h12345678);
        step();
        a_req = 1'b0;
        step();
        drive_b(1'b1, 1'b0, 4'd7, '0);
        #1;
        check("rr_b_gnt_solo", b_gnt, 1);
        step();
        b_req = 1'b0;
        step();
        check("mid_busy_resp", busy, 1);
        b_rv_seen = 1'b0;
        #1;
        RST_N = 1'b0;
        #1;
        check("async_busy", busy, 0);
        check("async_mem_en", mem_en, 0);
        check("async_rvalid", {a_rvalid, b_rvalid}, 0);
        check("async_rdata", b_rdata, 0);
        check("async_err", err, 0);
        step();
        RST_N = 1'b1;
        step();
        step();
        check("mid_no_b_rvalid", b_rv_seen, 0);
        drive_a(1'b1, 1'b0, 4'd0, '0);
        #1;
        check("post_a_gnt", a_gnt, 1);
        step();
        a_req = 1'b0;
        step();
        step();
        check("post_a_rvalid", a_rvalid, 1);
        check("post_a_rdata", a_rdata, 0);
        step();

        // Memory reports invalid data during RESP.
        drive_a(1'b1, 1'b0, 4'd3, '0);
        step();
        a_req = 1'b0;
        step();
        force_invalid = 1'b1;
        #1;
        check("err_before", err, 0);
        step();
        force_invalid = 1'b0;
        check("err_set", err, 1);
        check("err_rvalid", a_rvalid, 1);
        step();
        step();
        check("err_sticky", err, 1);
        RST_N = 1'b0;
        #1;
        check("err_cleared", err, 0);
        RST_N = 1'b1;
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
